// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data/address widths, transfer direction and
// the block-transfer FSM state encoding.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic DIR_STORE = 1'b0;
    localparam logic DIR_LOAD  = 1'b1;

    typedef enum logic [2:0] {
        RBT_IDLE = 3'd0,
        RBT_SCAN = 3'd1,
        RBT_REQ  = 3'd2,
        RBT_WB   = 3'd3,
        RBT_DONE = 3'd4
    } rbt_state_t;

endpackage

// File: rtl/lowest_set_bit16.sv
// Combinational 16-bit priority encoder: index of the lowest set bit,
// with o_valid low when the vector is all zeros.
module lowest_set_bit16 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx,
    output logic        o_valid
);

    always_comb begin
        o_idx   = 4'd0;
        o_valid = 1'b0;
        // Scanning downward lets the lowest set bit win the last assignment.
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = 4'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_block_transfer.sv
// Multi-register load/store engine moving mask-selected registers to/from
// consecutive memory words. Optional base writeback: RBT_BASE_WRITEBACK_EN.
import cpu_pkg::*;

module reg_block_transfer #(
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int ADDR_W    = cpu_pkg::ADDR_W,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              start,
    input  logic              dir,
    input  logic [15:0]       reg_mask,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        base_reg,
    output logic              busy,
    output logic              done,
    output logic [4:0]        xfer_count,
    output logic [3:0]        rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              rf_write_en,
    output logic [3:0]        rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        dbg_state
);

    rbt_state_t        r_state;
    logic [15:0]       r_mask;
    logic              r_dir;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [3:0]        r_idx;
    logic [4:0]        r_xfer_count;
`ifdef RBT_BASE_WRITEBACK_EN
    logic [3:0]        r_base_reg;
`else
    logic              w_unused_base_reg;
    assign w_unused_base_reg = ^base_reg;
`endif

    logic [3:0] w_low_idx;
    logic       w_low_valid;
    logic       w_in_req;

    lowest_set_bit16 u_lsb (
        .i_vec   (r_mask),
        .o_idx   (w_low_idx),
        .o_valid (w_low_valid)
    );

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= RBT_IDLE;
            r_mask       <= 16'd0;
            r_dir        <= DIR_STORE;
            r_cur_addr   <= '0;
            r_idx        <= 4'd0;
            r_xfer_count <= 5'd0;
`ifdef RBT_BASE_WRITEBACK_EN
            r_base_reg   <= 4'd0;
`endif
        end else begin
            case (r_state)
                RBT_IDLE: begin
                    if (start) begin
                        r_mask       <= reg_mask;
                        r_dir        <= dir;
                        r_cur_addr   <= base_addr;
                        r_xfer_count <= 5'd0;
`ifdef RBT_BASE_WRITEBACK_EN
                        r_base_reg   <= base_reg;
`endif
                        r_state      <= RBT_SCAN;
                    end
                end
                RBT_SCAN: begin
                    if (w_low_valid) begin
                        r_idx   <= w_low_idx;
                        r_state <= RBT_REQ;
                    end
`ifdef RBT_BASE_WRITEBACK_EN
                    else r_state <= RBT_WB;
`else
                    else r_state <= RBT_DONE;
`endif
                end
                RBT_REQ: begin
                    // Request fields come straight from registers, so they hold until ack.
                    if (mem_ack) begin
                        r_mask[r_idx] <= 1'b0;
                        r_cur_addr    <= r_cur_addr + ADDR_W'(ADDR_STEP);
                        r_xfer_count  <= r_xfer_count + 5'd1;
                        r_state       <= RBT_SCAN;
                    end
                end
`ifdef RBT_BASE_WRITEBACK_EN
                RBT_WB:   r_state <= RBT_DONE;
`endif
                RBT_DONE: r_state <= RBT_IDLE;
                default:  r_state <= RBT_IDLE;
            endcase
        end
    end

    assign w_in_req     = (r_state == RBT_REQ);
    assign busy         = (r_state != RBT_IDLE);
    assign done         = (r_state == RBT_DONE);
    assign xfer_count   = r_xfer_count;
    assign dbg_state    = r_state;
    assign rf_read_addr = r_idx;
    assign mem_req      = w_in_req;
    assign mem_we       = w_in_req && (r_dir == DIR_STORE);
    assign mem_addr     = w_in_req ? r_cur_addr   : '0;
    assign mem_wdata    = w_in_req ? rf_read_data : '0;

    // Load data is forwarded combinationally in the ack cycle.
    always_comb begin
        rf_write_en   = 1'b0;
        rf_write_addr = 4'd0;
        rf_write_data = '0;
        if (w_in_req && (r_dir == DIR_LOAD) && mem_ack) begin
            rf_write_en   = 1'b1;
            rf_write_addr = r_idx;
            rf_write_data = mem_rdata;
        end
`ifdef RBT_BASE_WRITEBACK_EN
        if (r_state == RBT_WB) begin
            rf_write_en   = 1'b1;
            rf_write_addr = r_base_reg;
            rf_write_data = DATA_W'(r_cur_addr);
        end
`endif
    end

endmodule

// File: tb/tb_reg_block_transfer.sv
// Self-checking bench for reg_block_transfer: register file and memory
// models, randomized operations, transfer-list reference model.
module tb_reg_block_transfer;
    import cpu_pkg::*;

`ifdef RBT_BASE_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    logic        clk = 1'b0;
    logic        nRESET = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] reg_mask = 16'd0;
    logic [15:0] base_addr = 16'd0;
    logic [3:0]  base_reg = 4'd0;
    logic        busy, done, rf_write_en, mem_req, mem_we;
    logic [4:0]  xfer_count;
    logic [3:0]  rf_read_addr, rf_write_addr;
    logic [15:0] rf_read_data, rf_write_data, mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic [2:0]  dbg_state;

    logic [15:0] rf [16];
    logic [15:0] mem [65536];
    logic [32:0] req_q [$];   // {we, addr, wdata}
    logic [19:0] rfw_q [$];   // {reg, data}
    logic [32:0] rq_e;
    logic [19:0] rw_e;
    logic [15:0] lat_addr, lat_wdata;
    logic        lat_we;

    int n_checks = 0;
    int n_fail = 0;
    int ack_dly = 0;
    int wait_cnt = 0;
    int req_cycles = 0;
    int rfw_count = 0;

    reg_block_transfer dut (
        .clk(clk), .nRESET(nRESET), .start(start), .dir(dir),
        .reg_mask(reg_mask), .base_addr(base_addr), .base_reg(base_reg),
        .busy(busy), .done(done), .xfer_count(xfer_count),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign rf_read_data = rf[rf_read_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Memory responder: ack after ack_dly wait cycles; random ack noise when idle.
    always @(negedge clk) begin
        if (mem_req) begin
            req_cycles++;
            if (wait_cnt == 0) begin
                lat_addr  = mem_addr;
                lat_we    = mem_we;
                lat_wdata = mem_wdata;
                if (req_q.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    rq_e = req_q.pop_front();
                    check("req_we", mem_we, rq_e[32]);
                    check("req_addr", mem_addr, rq_e[31:16]);
                    if (rq_e[32]) check("req_wdata", mem_wdata, rq_e[15:0]);
                end
            end else begin
                check("hold_addr", mem_addr, lat_addr);
                check("hold_we", mem_we, lat_we);
                check("hold_wdata", mem_wdata, lat_wdata);
            end
            if (wait_cnt >= ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) mem[mem_addr] = mem_wdata;
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                wait_cnt++;
            end
        end else begin
            wait_cnt  = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
        end
    end

    // Register-file write port observer.
    always @(negedge clk) begin
        #1;
        if (rf_write_en) begin
            rfw_count++;
            if (rfw_q.size() == 0) begin
                check("unexpected_rf_write", 32'd1, 32'd0);
            end else begin
                rw_e = rfw_q.pop_front();
                check("rf_waddr", rf_write_addr, rw_e[19:16]);
                check("rf_wdata", rf_write_data, rw_e[15:0]);
            end
            rf[rf_write_addr] = rf_write_data;
        end
    end

    task automatic run_op(input logic d, input logic [15:0] m, input logic [15:0] b,
                          input logic [3:0] br, input int dly, input bit poke, input string tag);
        int n = 0;
        int cyc = 0;
        int exp_cyc, rc0, rw0;
        logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                a = b + 16'(n);
                if (d == DIR_STORE) begin
                    req_q.push_back({1'b1, a, rf[i]});
                end else begin
                    req_q.push_back({1'b0, a, 16'h0});
                    rfw_q.push_back({4'(i), mem[a]});
                end
                n++;
            end
        end
        if (WB == 1) rfw_q.push_back({br, b + 16'(n)});
        exp_cyc = (n + 1) + n * (dly + 1) + 1 + WB;
        ack_dly = dly;
        rc0 = req_cycles;
        rw0 = rfw_count;
        @(negedge clk);
        start = 1'b1; dir = d; reg_mask = m; base_addr = b; base_reg = br;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                dir = 1'($urandom); reg_mask = 16'($urandom);
                base_addr = 16'($urandom); base_reg = 4'($urandom);
            end
            if (poke && cyc == 3) start = 1'b1;
            if (poke && cyc == 4) start = 1'b0;
            check({tag, "_busy"}, busy, 32'd1);
            if (done || cyc >= 2000) break;
        end
        check({tag, "_done_cycle"}, cyc, exp_cyc);
        check({tag, "_xfer_count"}, xfer_count, n);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 32'd0);
        check({tag, "_busy_after"}, busy, 32'd0);
        check({tag, "_idle"}, dbg_state, RBT_IDLE);
        check({tag, "_xfer_hold"}, xfer_count, n);
        check({tag, "_req_cycles"}, req_cycles - rc0, n * (dly + 1));
        check({tag, "_rf_writes"}, rfw_count - rw0, (d == DIR_LOAD ? n : 0) + WB);
        check({tag, "_req_q_empty"}, req_q.size(), 32'd0);
        check({tag, "_rfw_q_empty"}, rfw_q.size(), 32'd0);
        req_q.delete();
        rfw_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v15, old6, m;
        int guard;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);

        #1 nRESET = 1'b0;
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_mem_req", mem_req, 32'd0);
        check("rst_mem_we", mem_we, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rf_we", rf_write_en, 32'd0);
        check("rst_rf_waddr", rf_write_addr, 32'd0);
        check("rst_rf_raddr", rf_read_addr, 32'd0);
        check("rst_xfer", xfer_count, 32'd0);
        check("rst_state", dbg_state, RBT_IDLE);
        repeat (2) @(negedge clk);
        nRESET = 1'b1;

        rf[0] = 16'h1111; rf[2] = 16'h2222;
        run_op(DIR_STORE, 16'h0005, 16'h0100, 4'd9, 0, 0, "store5");
        check("store5_m100", mem[16'h0100], 16'h1111);
        check("store5_m101", mem[16'h0101], 16'h2222);

        mem[16'h0200] = 16'hAAAA; mem[16'h0201] = 16'h5555;
        run_op(DIR_LOAD, 16'h8001, 16'h0200, 4'd5, 3, 0, "load8001");
        check("load8001_r0", rf[0], 16'hAAAA);
        check("load8001_r15", rf[15], 16'h5555);

        run_op(DIR_STORE, 16'h0000, 16'h1234, 4'd1, 0, 0, "empty");

        v15 = rf[15];
        run_op(DIR_STORE, 16'hFFFF, 16'hFFFE, 4'd3, 0, 0, "full");
        check("full_m000d", mem[16'h000D], v15);
`ifdef RBT_BASE_WRITEBACK_EN
        check("full_wb_r3", rf[3], 16'h000E);
`endif

        run_op(DIR_STORE, 16'h0F0F, 16'h4000, 4'd7, 1, 1, "poke");

        // Reset in the third request of a four-register load.
        ack_dly = 4;
        old6 = rf[6];
        for (int k = 0; k < 4; k++) begin
            req_q.push_back({1'b0, 16'h0300 + 16'(k), 16'h0});
            rfw_q.push_back({4'(4 + k), mem[16'h0300 + 16'(k)]});
        end
        @(negedge clk);
        start = 1'b1; dir = DIR_LOAD; reg_mask = 16'h00F0; base_addr = 16'h0300;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(xfer_count == 5'd2 && mem_req) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reach_req3", guard < 200, 32'd1);
        #2 nRESET = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 32'd0);
        check("abort_busy", busy, 32'd0);
        check("abort_rf_we", rf_write_en, 32'd0);
        check("abort_done", done, 32'd0);
        check("abort_xfer", xfer_count, 32'd0);
        check("abort_r4", rf[4], mem[16'h0300]);
        check("abort_r6_untouched", rf[6], old6);
        req_q.delete();
        rfw_q.delete();
        repeat (2) @(negedge clk);
        nRESET = 1'b1;
        @(negedge clk);
        check("abort_idle", dbg_state, RBT_IDLE);
        run_op(DIR_LOAD, 16'h00F0, 16'h0300, 4'd2, 0, 0, "after_rst");

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 5))
                0:       m = 16'h0000;
                1:       m = 16'hFFFF;
                default: m = 16'($urandom);
            endcase
            run_op(1'($urandom_range(0, 1)), m, 16'($urandom), 4'($urandom),
                   $urandom_range(0, 3), 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
